// File: rtl/q_disp_pkg.sv
// q_disp_pkg: shared widths, FSM encoding, write-strobe bits and entry layout
package q_disp_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int INST_W_DEF = 64;
  localparam int TIME_W_DEF = 32;
  localparam int WR_GATE = 0;
  localparam int WR_MEAS = 1;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;
  // entry is packed msb-first as {time, inst, is_meas}
  function automatic int entry_w(int tw, int iw);
    return tw + iw + 1;
  endfunction
endpackage

// File: rtl/qdisp_fifo.sv
// qdisp_fifo: synchronous fifo with count/full/empty, push accepted on full when popping
module qdisp_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  // storage array, not reset
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers and occupancy, flushed on reset
  always_ff @(posedge clk)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/q_inst_dispatcher.sv
// q_inst_dispatcher: timestamps pushed quantum instructions and releases them on the run timeline
module q_inst_dispatcher
  import q_disp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              end_sig,
  input  logic              q_time_write,
  input  logic              q_time_sel,
  input  logic [63:0]       q_time_reg,
  input  logic [1:0]        q_reg_write,
  input  logic [INST_W-1:0] q_inst,
  output logic              q_full,
  output logic [INST_W-1:0] out_inst,
  output logic              out_is_meas,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              meas_valid,
  input  logic [5:0]        meas_qubit,
  input  logic              meas_bit,
  input  logic              meas_clr,
  output logic [63:0]       i_q_measurement,
  output logic [TIME_W-1:0] timer,
  output logic              late,
  output logic              overflow,
  output logic              idle
);
  localparam int EW = entry_w(TIME_W, INST_W);
  state_t state, state_next;
  logic [TIME_W-1:0] label, label_next, head_t, diff;
  logic [INST_W-1:0] head_inst;
  logic head_meas, push_req, push, pop, full, empty, active, due, unused_time_hi;
  logic [EW-1:0] head;
  logic [$clog2(DEPTH):0] count;
  logic [63:0] meas_next;
  assign unused_time_hi = ^q_time_reg[63:TIME_W];
  assign push_req = q_reg_write[WR_GATE] | q_reg_write[WR_MEAS];
  assign push = push_req && state != S_DRAIN;
  assign {head_t, head_inst, head_meas} = head;
  assign diff = timer - head_t;
  assign due = !diff[TIME_W-1];
  assign pop = active && !empty && due && (!out_valid || out_ready);
  assign q_full = count == ($clog2(DEPTH)+1)'(DEPTH);
  qdisp_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din({label_next, q_inst, q_reg_write[WR_MEAS]}),
    .dout(head), .count(count), .full(full), .empty(empty)
  );
  // fsm state register
  always_ff @(posedge clk)
    state <= !rst ? S_IDLE : state_next;
  // fsm transitions; drain exits once nothing is queued or presented
  always_comb
    state_next = state == S_IDLE ? (start ? S_RUN : S_IDLE) :
                 state == S_RUN ? (end_sig ? S_DRAIN : S_RUN) :
                 (empty && !out_valid ? S_IDLE : S_DRAIN);
  // fsm outputs
  always_comb begin
    active = state != S_IDLE;
    idle = state == S_IDLE && empty;
  end
  // timing label: absolute load or relative add
  always_comb
    label_next = q_time_write ? (q_time_sel ? label + q_time_reg[TIME_W-1:0] : q_time_reg[TIME_W-1:0]) : label;
  // measurement word: clear first, then the strobed bit
  always_comb begin
    meas_next = meas_clr ? '0 : i_q_measurement;
    if (meas_valid) meas_next[meas_qubit] = meas_bit;
  end
  // label, timeline, measurement word and sticky flags
  always_ff @(posedge clk)
    if (!rst) begin
      label <= '0;
      timer <= '0;
      i_q_measurement <= '0;
      late <= 1'b0;
      overflow <= 1'b0;
    end else begin
      label <= label_next;
      timer <= (active && state_next != S_IDLE) ? timer + 1'b1 : '0;
      i_q_measurement <= meas_next;
      late <= late | (pop && timer != head_t);
      overflow <= overflow | (push_req && (state == S_DRAIN || (full && !pop)));
    end
  // registered issue stage, held until the backend accepts
  always_ff @(posedge clk)
    if (!rst) begin
      out_valid <= 1'b0;
      out_inst <= '0;
      out_is_meas <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_inst <= head_inst;
      out_is_meas <= head_meas;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: doc/q_inst_dispatcher.md
Name: q_inst_dispatcher

Overview:
- Quantum-side receiver for the classical controller's quantum-issue interface: q_inst, q_reg_write, q_time_write, q_time_sel and q_time_reg.
- Timestamps each pushed quantum instruction against a timing label and buffers it in a FIFO.
- Releases each instruction to the qubit pulse backend when the run timeline reaches its timestamp.
- Collects per-qubit measurement results into the 64-bit i_q_measurement word that the controller reads back.

Parameters:
- DEPTH, 16: instruction queue entries (power of two).
- INST_W, 64: quantum instruction width.
- TIME_W, 32: timestamp and timeline width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  pulse: IDLE -> RUN.
- end_sig  in  1  pulse: RUN -> DRAIN.
- q_time_write  in  1  update timing label.
- q_time_sel  in  1  0 = absolute load, 1 = relative add.
- q_time_reg  in  64  timing operand; low TIME_W bits used.
- q_reg_write  in  2  bit0 = push gate instruction, bit1 = push measurement instruction.
- q_inst  in  INST_W  instruction to push.
- q_full  out  1  queue full; the controller must stall pushes.
- out_inst  out  INST_W  issued instruction.
- out_is_meas  out  1  issued entry is a measurement.
- out_valid  out  1  issue valid.
- out_ready  in  1  backend accepts.
- meas_valid  in  1  measurement result strobe.
- meas_qubit  in  6  qubit index.
- meas_bit  in  1  result value.
- meas_clr  in  1  clear result word.
- i_q_measurement  out  64  result word, bit n = qubit n.
- timer  out  TIME_W  current timeline.
- late  out  1  sticky: an entry issued after its timestamp.
- overflow  out  1  sticky: a push was dropped while full.
- idle  out  1  state == IDLE and queue empty.

Behaviour:
- Reset (rst = 0 at clock edge): state IDLE, FIFO flushed, label = 0, timer = 0.
- Reset values of outputs: out_valid = 0, out_inst = 0, out_is_meas = 0, i_q_measurement = 0, late = 0, overflow = 0, q_full = 0, idle = 1.
- Reset mid-run discards all queued and in-flight entries without issuing them.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: timer held at 0; pushes accepted; no issue; start -> RUN.
  - RUN: timer increments by 1 each cycle, wrapping mod 2^TIME_W; issue enabled; end_sig -> DRAIN.
  - DRAIN: timer keeps counting; pushes ignored and flagged as overflow; when FIFO is empty and out_valid is 0 -> IDLE, where timer resets to 0 on entry.
  - start is ignored outside IDLE; end_sig is ignored outside RUN.
- Timing label:
  - q_time_write with q_time_sel = 0: label_next = q_time_reg[TIME_W-1:0].
  - q_time_write with q_time_sel = 1: label_next = label + q_time_reg[TIME_W-1:0], mod 2^TIME_W.
  - Otherwise label_next = label.
- Push (any bit of q_reg_write set, not full): writes entry {label_next, q_inst, q_reg_write[1]}.
  - A push in the same cycle as a label write uses the new label.
  - q_reg_write = 2'b11 is a measurement push.
- Push while full: entry dropped, overflow <= 1.
  - A push and a pop in the same cycle while full is accepted.
- Due test: head is due when (timer − head.time) mod 2^TIME_W has MSB = 0. This is wrap-safe within half range.
- Issue stage (registered): when state is RUN/DRAIN, the head is due, and (out_valid = 0 or out_ready = 1), pop the head into out_inst/out_is_meas and set out_valid = 1 on the next cycle.
  - Latency: head due at cycle t -> out_valid at t+1.
  - At most one issue per cycle.
  - When out_valid = 1 and out_ready = 1 with no due head: out_valid <= 0.
  - out_valid held with stable data until out_ready.
- late <= 1 when a popped entry has timer ≠ head.time at pop.
- late and overflow clear only on reset.
- q_full = (count == DEPTH).
- Measurement word update order: meas_clr first zeroes the word; then meas_valid writes bit meas_qubit = meas_bit in the same cycle.

Decomposition:
- Package q_disp_pkg holds:
  - TIME_W / INST_W defaults;
  - FSM state encoding (IDLE = 0, RUN = 1, DRAIN = 2);
  - entry layout {time, inst, is_meas};
  - q_reg_write bit positions.
- Sub-module qdisp_fifo: synchronous FIFO with count, full, empty; single push and pop per cycle; flush on rst.

Test Plan:
1. Absolute timing: label := 10, push gate inst 0xA5, start; timer reaches 10 -> out_valid = 1 with out_inst = 0xA5 exactly one cycle later (timer = 11); late = 0.
2. Relative timing with same-cycle write: label := 5, then a relative +3 write and a push of 0x1 in the same cycle -> the entry is stamped 8 and issues at timer = 9.
3. Backpressure: two entries stamped 4, out_ready = 0 until timer = 20 -> out_inst holds the first entry; the second issues afterwards with late = 1.
4. Full queue: DEPTH+1 pushes in IDLE -> q_full = 1 after 16 pushes, the 17th is dropped, overflow = 1, only 16 issue.
5. Measurement word: meas_valid qubit 63 bit 1, then qubit 0 bit 1 -> i_q_measurement = 0x8000_0000_0000_0001; meas_clr together with meas_valid qubit 2 = 1 -> 0x4.
6. Drain and reset: end_sig with 3 entries queued -> all issue, then idle = 1 and timer = 0; a separate run with rst = 0 mid-run -> out_valid = 0 next cycle, FIFO empty, no further issues.
